// File: rtl/online_to_binary_converter.sv
// On-line to binary converter: accepts a frame of signed radix-2 borrow-save digits, MSD first,
// and builds the two's-complement result on the fly with the Q/QM scheme.
module online_to_binary_converter #(
  parameter int unsigned NDIGITS = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       dig_i,
  input  logic             dig_vld_i,
  output logic             dig_rdy_o,
  output logic [NDIGITS:0] res_o,
  output logic             res_vld_o,
  input  logic             res_rdy_i,
  output logic             res_zero_o,
  output logic             res_neg_o
);

  localparam int unsigned W    = NDIGITS + 1;
  localparam int unsigned CntW = $clog2(NDIGITS);

  typedef enum logic {StCollect, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [W-1:0]    q_q, qm_q, q_d, qm_d, res_q;
  logic            dig_rdy_q, res_vld_q, res_zero_q, res_neg_q;
  logic            dig_pos, dig_neg, accept, last_dig;

  // 2'b00 and 2'b11 both encode zero.
  assign dig_pos  = dig_i[1] & ~dig_i[0];
  assign dig_neg  = dig_i[0] & ~dig_i[1];
  assign accept   = dig_vld_i & dig_rdy_q;
  assign last_dig = (cnt_q == CntW'(NDIGITS - 1));

  // Q holds the prefix value, QM = Q - 1; a -1 digit selects from QM so no carry ripples.
  always_comb begin
    q_d  = {q_q[W-2:0], 1'b0};
    qm_d = {qm_q[W-2:0], 1'b1};
    if (dig_pos) begin
      q_d  = {q_q[W-2:0], 1'b1};
      qm_d = {q_q[W-2:0], 1'b0};
    end else if (dig_neg) begin
      q_d  = {qm_q[W-2:0], 1'b1};
      qm_d = {qm_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StCollect;
      cnt_q      <= '0;
      q_q        <= '0;
      qm_q       <= '1;
      res_q      <= '0;
      dig_rdy_q  <= 1'b0;
      res_vld_q  <= 1'b0;
      res_zero_q <= 1'b0;
      res_neg_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StCollect: begin
          dig_rdy_q <= 1'b1;
          if (accept) begin
            q_q  <= q_d;
            qm_q <= qm_d;
            if (last_dig) begin
              cnt_q      <= '0;
              res_q      <= q_d;
              res_zero_q <= (q_d == '0);
              res_neg_q  <= q_d[W-1];
              res_vld_q  <= 1'b1;
              dig_rdy_q  <= 1'b0;
              state_q    <= StDone;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StDone: begin
          if (res_rdy_i) begin
            res_vld_q <= 1'b0;
            dig_rdy_q <= 1'b1;
            q_q       <= '0;
            qm_q      <= '1;
            state_q   <= StCollect;
          end
        end
      endcase
    end
  end

  assign dig_rdy_o  = dig_rdy_q;
  assign res_o      = res_q;
  assign res_vld_o  = res_vld_q;
  assign res_zero_o = res_zero_q;
  assign res_neg_o  = res_neg_q;

endmodule

// File: tb/tb_online_to_binary_converter.sv
// Scoreboard bench for online_to_binary_converter with NDIGITS=4: directed frames push expected
// results, an independent monitor pops and compares on every res_vld & res_rdy transfer.
module tb_online_to_binary_converter;

  localparam int unsigned N = 4;
  localparam int unsigned W = N + 1;

  // Digit value = dig[1] - dig[0].
  localparam logic [1:0] DP  = 2'b10;
  localparam logic [1:0] DM  = 2'b01;
  localparam logic [1:0] DZ  = 2'b00;
  localparam logic [1:0] DZ2 = 2'b11;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         neg;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   dig = 2'b00;
  logic         dig_vld = 1'b0;
  logic         dig_rdy;
  logic [W-1:0] res;
  logic         res_vld;
  logic         res_rdy = 1'b1;
  logic         res_zero;
  logic         res_neg;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_results = 0;

  online_to_binary_converter #(.NDIGITS(N)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .dig_i      (dig),
    .dig_vld_i  (dig_vld),
    .dig_rdy_o  (dig_rdy),
    .res_o      (res),
    .res_vld_o  (res_vld),
    .res_rdy_i  (res_rdy),
    .res_zero_o (res_zero),
    .res_neg_o  (res_neg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int v);
    exp_t e;
    e.res  = W'(v);
    e.zero = (v == 0);
    e.neg  = (v < 0);
    return e;
  endfunction

  // Monitor: transfers are sampled mid-cycle, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && res_vld && res_rdy) begin
        n_results++;
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(res), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("res", 32'(res), 32'(e.res));
          check("res_zero", 32'(res_zero), 32'(e.zero));
          check("res_neg", 32'(res_neg), 32'(e.neg));
        end
      end
    end
  end

  // Inputs change 1 time unit after posedge; a digit counts if dig_rdy was high at the next edge.
  task automatic send_digit(input logic [1:0] d, input int gap);
    logic rdy;
    int   t;
    repeat (gap) begin
      dig_vld = 1'b0;
      dig     = DP;
      @(posedge clk); #1;
    end
    dig     = d;
    dig_vld = 1'b1;
    t       = 0;
    do begin
      rdy = dig_rdy;
      @(posedge clk); #1;
      t++;
    end while (!rdy && t < 200);
    if (!rdy) check("digit_timeout", 32'(t), 32'(0));
    dig_vld = 1'b0;
  endtask

  task automatic send_frame(input logic [1:0] d0, input logic [1:0] d1, input logic [1:0] d2,
                            input logic [1:0] d3, input int exp_v, input logic [3:0] gaps);
    sb.push_back(mk(exp_v));
    send_digit(d0, gaps[0] ? 2 : 0);
    send_digit(d1, gaps[1] ? 1 : 0);
    send_digit(d2, gaps[2] ? 3 : 0);
    send_digit(d3, gaps[3] ? 1 : 0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    check("rst_res", 32'(res), 32'(0));
    check("rst_res_vld", 32'(res_vld), 32'(0));
    check("rst_res_zero", 32'(res_zero), 32'(0));
    check("rst_res_neg", 32'(res_neg), 32'(0));
    check("rst_dig_rdy", 32'(dig_rdy), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #2;
    check("rdy_before_edge", 32'(dig_rdy), 32'(0));
    @(posedge clk); #1;
    check("rdy_after_edge", 32'(dig_rdy), 32'(1));

    // 1: +1,0,-1,+1 = 7, result valid for exactly one cycle
    send_frame(DP, DZ, DM, DP, 7, 4'b0000);
    check("t1_vld_hi", 32'(res_vld), 32'(1));
    check("t1_rdy_lo", 32'(dig_rdy), 32'(0));
    @(posedge clk); #1;
    check("t1_vld_lo", 32'(res_vld), 32'(0));
    check("t1_rdy_hi", 32'(dig_rdy), 32'(1));
    wait_idle();

    // 2: extremes, back to back
    send_frame(DM, DM, DM, DM, -15, 4'b0000);
    send_frame(DP, DP, DP, DP, 15, 4'b0000);
    wait_idle();

    // 3: both zero encodings, then redundant 8-4-2-1
    send_frame(DZ, DZ2, DZ2, DZ, 0, 4'b0000);
    send_frame(DP, DM, DM, DM, 1, 4'b0000);
    wait_idle();

    // 4: backpressure with the next frame already offered
    res_rdy = 1'b0;
    send_frame(DP, DZ, DM, DP, 7, 4'b0000);
    fork
      send_frame(DM, DZ, DZ, DP, -7, 4'b0000);
      begin
        repeat (5) begin
          check("bp_dig_rdy", 32'(dig_rdy), 32'(0));
          check("bp_res_vld", 32'(res_vld), 32'(1));
          check("bp_res_hold", 32'(res), 32'(7));
          @(posedge clk); #1;
        end
        res_rdy = 1'b1;
      end
    join
    wait_idle();

    // 5: gaps within the frame
    send_frame(DP, DZ, DM, DP, 7, 4'b1011);
    wait_idle();

    // 6: reset after two digits, then a clean frame
    send_digit(DM, 0);
    send_digit(DM, 0);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    check("t6_rdy_after_rst", 32'(dig_rdy), 32'(0));
    send_frame(DP, DP, DZ, DZ, 12, 4'b0000);
    wait_idle();

    // 7: reset while a result is pending drops it immediately
    res_rdy = 1'b0;
    send_frame(DP, DP, DP, DM, 13, 4'b0000);
    check("t7_vld_pending", 32'(res_vld), 32'(1));
    rst_n = 1'b0;
    #1;
    check("t7_vld_dropped", 32'(res_vld), 32'(0));
    check("t7_res_cleared", 32'(res), 32'(0));
    check("t7_sb_pending", 32'(sb.size()), 32'(1));
    if (sb.size() != 0) void'(sb.pop_front());
    #2;
    rst_n   = 1'b1;
    res_rdy = 1'b1;
    send_frame(DZ, DZ, DZ, DP, 1, 4'b0000);
    wait_idle();

    repeat (3) @(posedge clk);
    #1;
    check("result_count", 32'(n_results), 32'(10));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
